fighter_player: RTL and testbench

- Per-player game-logic block for the two-fighter VGA game.
- Clocked by the once-per-frame tick (60 Hz end-of-frame pulse, or a manual step key).
- Decodes left/right/attack buttons into a movement/attack state machine and tracks the player's 100x100 sprite position on a 640x480 screen.
- Drives state, position, body hurtbox and attack-limb box to the renderer and the collision logic.

---
 rtl/fighter_player.sv | 140 ++++++++++++++
 tb/tb_fighter_player.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/fighter_player.sv
// Per-player game logic for the two-fighter game: movement/attack state machine,
// saturating sprite position, body hurtbox and attack-limb box, advanced once per frame tick.
module fighter_player #(
    parameter logic        SIDE           = 1'b0,
    parameter int unsigned SPEED_FWD      = 3,
    parameter int unsigned SPEED_BACK     = 2,
    parameter int unsigned STARTUP_TICKS  = 5,
    parameter int unsigned ACTIVE_TICKS   = 3,
    parameter int unsigned RECOVERY_TICKS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       left,
    input  logic       right,
    input  logic       attack,
    output logic [9:0] posx,
    output logic [9:0] posy,
    output logic [3:0] current_state,
    output logic [9:0] basic_hithurtbox_x1,
    output logic [9:0] basic_hithurtbox_x2,
    output logic [9:0] basic_hithurtbox_y1,
    output logic [9:0] basic_hithurtbox_y2,
    output logic [9:0] main_hurtbox_x1,
    output logic [9:0] main_hurtbox_x2,
    output logic [9:0] main_hurtbox_y1,
    output logic [9:0] main_hurtbox_y2
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FWD       = 4'd1,
        S_BACK      = 4'd2,
        S_ATK_START = 4'd3,
        S_ATK_END   = 4'd4,
        S_ATK_PULL  = 4'd5
    } state_t;

    localparam int unsigned TOTAL_TICKS = STARTUP_TICKS + ACTIVE_TICKS + RECOVERY_TICKS;
    localparam int unsigned CW          = $clog2(TOTAL_TICKS + 1);
    localparam logic [10:0] MAX_X       = 11'd540;
    localparam logic [9:0]  SPAWN_X     = SIDE ? 10'd440 : 10'd100;
    localparam logic [9:0]  POS_Y       = 10'd300;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [9:0]      posx_n;
    logic            fwd_held, back_held;
    logic [9:0]      reach;

    // Saturating horizontal step; 11-bit math so the right edge can never wrap.
    function automatic logic [9:0] step_x(input logic [9:0] x, input logic go_right,
                                          input logic [10:0] amt);
        logic [10:0] sum;
        sum = {1'b0, x} + amt;
        if (go_right)
            step_x = (sum > MAX_X) ? MAX_X[9:0] : sum[9:0];
        else
            step_x = ({1'b0, x} < amt) ? 10'd0 : (x - amt[9:0]);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            posx  <= SPAWN_X;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            posx  <= posx_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        posx_n    = posx;
        fwd_held  = SIDE ? (left && !right) : (right && !left);
        back_held = SIDE ? (right && !left) : (left && !right);
        case (state)
            S_IDLE, S_FWD, S_BACK: begin
                if (attack) begin
                    state_n = S_ATK_START;
                    cnt_n   = '0;
                end else if (fwd_held) begin
                    state_n = S_FWD;
                    posx_n  = step_x(posx, ~SIDE, 11'(SPEED_FWD));
                end else if (back_held) begin
                    state_n = S_BACK;
                    posx_n  = step_x(posx, SIDE, 11'(SPEED_BACK));
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_ATK_START, S_ATK_END, S_ATK_PULL: begin
                // Counter runs across all three phases; phase boundaries are cumulative tick counts.
                cnt_n = cnt + 1'b1;
                if (cnt_n == CW'(STARTUP_TICKS))
                    state_n = S_ATK_END;
                else if (cnt_n == CW'(STARTUP_TICKS + ACTIVE_TICKS))
                    state_n = S_ATK_PULL;
                else if (cnt_n == CW'(TOTAL_TICKS)) begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_comb begin
        reach               = 10'd0;
        basic_hithurtbox_x1 = 10'd0;
        basic_hithurtbox_x2 = 10'd0;
        basic_hithurtbox_y1 = 10'd0;
        basic_hithurtbox_y2 = 10'd0;
        if (state == S_ATK_START || state == S_ATK_END || state == S_ATK_PULL) begin
            reach               = (state == S_ATK_END) ? 10'd60 : 10'd30;
            basic_hithurtbox_y1 = POS_Y + 10'd20;
            basic_hithurtbox_y2 = POS_Y + 10'd39;
            if (!SIDE) begin
                basic_hithurtbox_x1 = posx + 10'd100;
                basic_hithurtbox_x2 = posx + 10'd99 + reach;
            end else begin
                basic_hithurtbox_x1 = (posx < reach) ? 10'd0 : (posx - reach);
                basic_hithurtbox_x2 = (posx == 10'd0) ? 10'd0 : (posx - 10'd1);
            end
        end
    end

    assign posy            = POS_Y;
    assign current_state   = state;
    assign main_hurtbox_x1 = posx;
    assign main_hurtbox_x2 = posx + 10'd99;
    assign main_hurtbox_y1 = POS_Y;
    assign main_hurtbox_y2 = POS_Y + 10'd99;

endmodule

// File: tb/tb_fighter_player.sv
// Directed bench for fighter_player: one left-side and one right-side instance sharing clock and reset.
module tb_fighter_player;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic l0 = 1'b0, r0 = 1'b0, a0 = 1'b0;
    logic l1 = 1'b0, r1 = 1'b0, a1 = 1'b0;

    logic [9:0] px0, py0, hx1_0, hx2_0, hy1_0, hy2_0, mx1_0, mx2_0, my1_0, my2_0;
    logic [9:0] px1, py1, hx1_1, hx2_1, hy1_1, hy2_1, mx1_1, mx2_1, my1_1, my2_1;
    logic [3:0] st0, st1;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    fighter_player #(.SIDE(1'b0)) u_p0 (
        .clk(clk), .rst(rst), .left(l0), .right(r0), .attack(a0),
        .posx(px0), .posy(py0), .current_state(st0),
        .basic_hithurtbox_x1(hx1_0), .basic_hithurtbox_x2(hx2_0),
        .basic_hithurtbox_y1(hy1_0), .basic_hithurtbox_y2(hy2_0),
        .main_hurtbox_x1(mx1_0), .main_hurtbox_x2(mx2_0),
        .main_hurtbox_y1(my1_0), .main_hurtbox_y2(my2_0)
    );

    fighter_player #(.SIDE(1'b1)) u_p1 (
        .clk(clk), .rst(rst), .left(l1), .right(r1), .attack(a1),
        .posx(px1), .posy(py1), .current_state(st1),
        .basic_hithurtbox_x1(hx1_1), .basic_hithurtbox_x2(hx2_1),
        .basic_hithurtbox_y1(hy1_1), .basic_hithurtbox_y2(hy2_1),
        .main_hurtbox_x1(mx1_1), .main_hurtbox_x2(mx2_1),
        .main_hurtbox_y1(my1_1), .main_hurtbox_y2(my2_1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int unsigned exp_st;

        // Reset values for both sides
        #12;
        check("rst_st0", st0, 0);
        check("rst_px0", px0, 100);
        check("rst_py0", py0, 300);
        check("rst_limb0", hx1_0 | hx2_0 | hy1_0 | hy2_0, 0);
        check("rst_mx1", mx1_0, 100);
        check("rst_mx2", mx2_0, 199);
        check("rst_my1", my1_0, 300);
        check("rst_my2", my2_0, 399);
        check("rst_px1", px1, 440);
        rst = 1'b1;

        // Left player: forward, backward, both held
        r0 = 1'b1; tick(10);
        check("fwd_st", st0, 1);
        check("fwd_px", px0, 130);
        r0 = 1'b0; l0 = 1'b1; tick(5);
        check("back_st", st0, 2);
        check("back_px", px0, 120);
        r0 = 1'b1; tick(1);
        check("both_st", st0, 0);
        check("both_px", px0, 120);
        l0 = 1'b0; r0 = 1'b0;

        // Right player: forward is left, backward saturates at 540
        l1 = 1'b1; tick(4);
        check("p1_fwd_px", px1, 428);
        check("p1_fwd_st", st1, 1);
        l1 = 1'b0; r1 = 1'b1; tick(60);
        check("p1_clamp_px", px1, 540);
        check("p1_clamp_st", st1, 2);
        r1 = 1'b0;

        // Left player down to 1, then clamp at 0
        r0 = 1'b1; tick(1);
        r0 = 1'b0; l0 = 1'b1; tick(61);
        check("to1_px", px0, 1);
        tick(1);
        check("clamp0_px", px0, 0);
        check("clamp0_st", st0, 2);
        l0 = 1'b0; r0 = 1'b1; tick(34);
        r0 = 1'b0; l0 = 1'b1; tick(1);
        l0 = 1'b0;
        check("back100_px", px0, 100);

        // Single-edge attack pulse with movement held throughout
        a0 = 1'b1; tick(1);
        a0 = 1'b0; r0 = 1'b1;
        check("atk_k0", st0, 3);
        check("start_hx1", hx1_0, 200);
        check("start_hx2", hx2_0, 229);
        for (int unsigned k = 1; k <= 16; k++) begin
            tick(1);
            exp_st = (k < 5) ? 3 : (k < 8) ? 4 : (k < 16) ? 5 : 0;
            check($sformatf("atk_k%0d", k), st0, exp_st);
            if (k == 5) begin
                check("act_hx1", hx1_0, 200);
                check("act_hx2", hx2_0, 259);
                check("act_hy1", hy1_0, 320);
                check("act_hy2", hy2_0, 339);
            end
        end
        check("atk_frozen_px", px0, 100);
        check("atk_end_limb", hx1_0 | hx2_0 | hy1_0 | hy2_0, 0);

        // Attack beats movement; reset during active phase is immediate
        a0 = 1'b1; r0 = 1'b1; tick(1);
        a0 = 1'b0; r0 = 1'b0;
        check("prio_st", st0, 3);
        check("prio_px", px0, 100);
        tick(5);
        check("pre_rst_st", st0, 4);
        #2 rst = 1'b0;
        #1;
        check("async_rst_st", st0, 0);
        check("async_rst_px", px0, 100);
        check("async_rst_px1", px1, 440);
        #1 rst = 1'b1;

        // Right player limb clamps at the left screen edge
        l1 = 1'b1; tick(140);
        l1 = 1'b0;
        check("p1_20_px", px1, 20);
        a1 = 1'b1; tick(1);
        a1 = 1'b0;
        check("p1_start_hx1", hx1_1, 0);
        check("p1_start_hx2", hx2_1, 19);
        tick(5);
        check("p1_act_st", st1, 4);
        check("p1_act_hx1", hx1_1, 0);
        check("p1_act_hx2", hx2_1, 19);
        check("p1_act_hy1", hy1_1, 320);
        check("p1_act_hy2", hy2_1, 339);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
